// File: rtl/c3_path_pkg.sv
// Shared types and constants for the c3_path capture/MISR slice.
package c3_path_pkg;

  localparam int unsigned MISR_W = 8;
  localparam int unsigned CAP_W  = 3;

  localparam logic [MISR_W-1:0] DEF_POLY = 8'h1D;
  localparam logic [MISR_W-1:0] DEF_SEED = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One MISR update: shift left, feed back the tap parity, fold in the capture word.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [CAP_W-1:0]  din,
                                                  input logic [MISR_W-1:0] poly);
    logic fb;
    fb = ^(sig & poly);
    return {sig[MISR_W-2:0], fb} ^ {(MISR_W-CAP_W)'(0), din};
  endfunction

endpackage

// File: rtl/c3_misr8.sv
// 8-bit multiple-input signature register; load takes priority over enable.
module c3_misr8
  import c3_path_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [MISR_W-1:0] seed,
  input  logic [CAP_W-1:0]  din,
  input  logic [MISR_W-1:0] poly,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_d;
  logic [MISR_W-1:0] sig_q;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = misr_next(sig_q, din, poly);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c3_path_capture_misr.sv
// Endpoint capture flops for c3_path plus a fixed-length MISR compaction run.
module c3_path_capture_misr #(
  parameter int unsigned MISR_W         = 8,
  parameter int unsigned CAPTURE_CYCLES = 16,
  parameter logic [7:0]  POLY           = c3_path_pkg::DEF_POLY,
  parameter logic [7:0]  SEED           = c3_path_pkg::DEF_SEED
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic              nx33,
  input  logic              nx44,
  input  logic              nx12,
  output logic [2:0]        cap_q,
  output logic [MISR_W-1:0] signature,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      CNT_W    = $clog2(CAPTURE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAPTURE_CYCLES - 1);

  c3_path_pkg::state_e state_d, state_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [2:0]          cap_d;
  logic                misr_load;
  logic                misr_en;

  assign cap_d = {nx12, nx44, nx33};

  // Next-state: start is only honoured outside RUN; RUN exits on the terminal count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      c3_path_pkg::IDLE, c3_path_pkg::DONE: begin
        if (start) begin
          state_d   = c3_path_pkg::RUN;
          cnt_d     = '0;
          misr_load = 1'b1;
        end
      end
      c3_path_pkg::RUN: begin
        misr_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = c3_path_pkg::DONE;
        end
      end
      default: begin
        state_d = c3_path_pkg::IDLE;
      end
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q <= c3_path_pkg::IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  c3_misr8 u_misr (
    .clk  (blif_clk_net),
    .rst  (blif_reset_net),
    .load (misr_load),
    .en   (misr_en),
    .seed (SEED),
    .din  (cap_q),
    .poly (POLY),
    .sig  (signature)
  );

  assign busy = (state_q == c3_path_pkg::RUN);
  assign done = (state_q == c3_path_pkg::DONE);

endmodule
